hpu_darb_mp: RTL and testbench
==============================

Name: hpu_darb_mp

Overview:
- Parametrised successor of the debug-memory arbiter: merges one debug-controller response channel and NUM_PORTS generic requesters onto the single debug-memory (DM) port.
- Requesters are, e.g., port 0 = instruction fetch and port 1 = LSU; more can be added for future harts or trace.
- Adds an explicit grant handshake, byte-strobe forwarding, a configurable DM read latency, and per-port read-response routing.
- Sits between the hpu pipeline (ctrl/if/lsu) and the DM.

Parameters:
- NUM_PORTS, 2, number of requester ports (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- RD_LAT, 1, DM read latency in cycles, counted from the DM request cycle to valid dm_darb__rdata_i (1..4).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- ctrl_darb__rspd_en_i  in  1  debug-controller response strobe.
- ctrl_darb__rspd_data_i  in  rspd_e  response code.
- req_darb__req_i  in  NUM_PORTS  per-port request.
- req_darb__we_i  in  NUM_PORTS  per-port write enable.
- req_darb__addr_i  in  NUM_PORTS*ADDR_W  per-port address, packed with port 0 in the LSBs.
- req_darb__wdata_i  in  NUM_PORTS*DATA_W  per-port write data.
- req_darb__wstrb_i  in  NUM_PORTS*DATA_W/8  per-port byte strobes.
- darb_req__gnt_o  out  NUM_PORTS  one-hot grant.
- darb_req__rvalid_o  out  NUM_PORTS  one-hot read-data valid.
- darb_req__rdata_o  out  DATA_W  read data, shared by all ports.
- darb_dm__req_o  out  1  DM request, registered.
- darb_dm__we_o  out  1  DM write enable, registered.
- darb_dm__addr_o  out  ADDR_W  DM address, registered.
- darb_dm__wdata_o  out  DATA_W  DM write data, registered.
- darb_dm__wstrb_o  out  DATA_W/8  DM byte strobes, registered.
- dm_darb__rdata_i  in  DATA_W  DM read data.

Behaviour:
- Reset: all registered DM outputs are 0; the response pipe is cleared; the round-robin pointer is 0. darb_req__gnt_o and darb_req__rvalid_o read 0 in the reset cycle.
- Priority:
  - rspd_en_i beats every requester.
  - When rspd_en_i is high, no grant is issued that cycle.
  - The DM request in the next cycle is: we=1, wdata=0, wstrb=all ones.
  - Address by response code: RSPD_HALT→0x100, RSPD_CMD→0x104, RSPD_RESUME→0x108, any other code→0x10C.
- Requester arbitration (cycle with rspd_en_i low):
  - Exactly one requesting port is granted; gnt_o is combinational in the same cycle.
  - The requester holds req/we/addr/wdata/wstrb stable until it sees gnt.
  - A granted transaction appears on the darb_dm__* outputs on the next clock.
- No requests and no rspd: darb_dm__req_o=0 next cycle; addr, wdata and wstrb are also driven to 0.
- Read response:
  - Each granted read pushes its one-hot port id into an RD_LAT-deep shift pipe; writes and rspd writes push 0.
  - rvalid_o equals the pipe output, so it asserts exactly RD_LAT cycles after the DM request cycle (RD_LAT+1 cycles after gnt).
  - rdata_o passes dm_darb__rdata_i straight through.
- Back-to-back: reads may be granted every cycle; responses return in order, and each is routed only to the port that issued it.
- Writes have no response; gnt is the completion.
- Synchronous reset in mid-flight drops all in-flight responses; no rvalid is produced after reset.
- If NUM_PORTS=1 the arbiter degenerates to a pass-through gated only by rspd.

Optional Feature:
- HPU_DARB_RR_EN defined:
  - Round-robin among requesters.
  - The pointer advances to (granted port + 1) mod NUM_PORTS after each requester grant; it is unchanged on rspd-only or idle cycles.
- Undefined: fixed priority, lowest port index wins (port 0 = fetch is highest).

Decomposition:
- hpu_pkg gains:
  - rspd_e, if not already present.
  - DARB_HALT_ADDR, DARB_CMD_ADDR, DARB_RESUME_ADDR, DARB_EXCP_ADDR = 0x100/0x104/0x108/0x10C.
  - darb_port_id_t as a one-hot vector type.
- One natural sub-module: hpu_darb_arb. It is the combinational/registered NUM_PORTS arbiter with a rr/fixed mode input and produces the one-hot grant.

Test Plan:
- Fixed priority (macro off), NUM_PORTS=2:
  - Stimulus: req=2'b11, both reads, port0 addr 0x200, port1 addr 0x300.
  - Response: gnt=01, then 10; DM addr 0x200 then 0x300 on consecutive cycles.
  - rvalid=01 then 10, each RD_LAT cycles after its DM request.
- Round robin (macro on), NUM_PORTS=3:
  - Stimulus: req=3'b111 held for 6 cycles.
  - Response: gnt sequence 001,010,100,001,010,100.
- Response precedence:
  - Stimulus: rspd_en_i=1 with RSPD_RESUME while port0 requests.
  - Response: no gnt that cycle; DM we=1, addr 0x108, wdata 0, wstrb 0xF.
  - Port0 is granted the following cycle.
- Write with strobes:
  - Stimulus: port1 writes addr 0x40, wdata 0xDEADBEEF, wstrb 0x3.
  - Response: DM we=1, addr 0x40, wdata 0xDEADBEEF, wstrb 0x3 next cycle; no rvalid.
- Latency:
  - Stimulus: RD_LAT=3, one read from port0 with DM returning 0x1234.
  - Response: rvalid_o=01 and rdata_o=0x1234 exactly 3 cycles after darb_dm__req_o.
- Reset mid-flight:
  - Stimulus: RD_LAT=2, read granted, rst_i asserted one cycle later.
  - Response: no rvalid ever; all DM outputs 0 on the cycle after reset.

Source files
------------

// File: rtl/hpu_pkg.sv
// Shared hpu types and constants: debug-controller response codes, the fixed
// debug-memory mailbox addresses and the one-hot requester id used by the arbiter.
package hpu_pkg;

  typedef enum logic [1:0] {
    RSPD_HALT   = 2'd0,
    RSPD_CMD    = 2'd1,
    RSPD_RESUME = 2'd2,
    RSPD_EXCP   = 2'd3
  } rspd_e;

  localparam logic [31:0] DARB_HALT_ADDR   = 32'h0000_0100;
  localparam logic [31:0] DARB_CMD_ADDR    = 32'h0000_0104;
  localparam logic [31:0] DARB_RESUME_ADDR = 32'h0000_0108;
  localparam logic [31:0] DARB_EXCP_ADDR   = 32'h0000_010C;

  localparam int DARB_MAX_PORTS = 8;

  // One-hot requester id; ports above NUM_PORTS stay zero.
  typedef logic [DARB_MAX_PORTS-1:0] darb_port_id_t;

  function automatic logic [31:0] darb_rspd_addr(input rspd_e code);
    case (code)
      RSPD_HALT:   darb_rspd_addr = DARB_HALT_ADDR;
      RSPD_CMD:    darb_rspd_addr = DARB_CMD_ADDR;
      RSPD_RESUME: darb_rspd_addr = DARB_RESUME_ADDR;
      default:     darb_rspd_addr = DARB_EXCP_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/hpu_darb_arb.sv
// NUM_PORTS requester arbiter with a combinational one-hot grant. With rr_en_i set the
// search starts at a rotating pointer, otherwise the lowest index always wins.
module hpu_darb_arb
  import hpu_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rr_en_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0]       ptr_reg, ptr_next;
  logic [PTR_W-1:0]       base;
  logic [2*NUM_PORTS-1:0] dbl_req, dbl_gnt;
  logic [NUM_PORTS-1:0]   rot_req, rot_gnt;

  // Rotate requests so the pointer position sits at bit 0, take the lowest set bit,
  // then rotate the winner back into place.
  always_comb begin
    base    = rr_en_i ? ptr_reg : '0;
    dbl_req = {req_i, req_i} >> base;
    rot_req = dbl_req[NUM_PORTS-1:0];
    rot_gnt = rot_req & (~rot_req + NUM_PORTS'(1));
    dbl_gnt = {rot_gnt, rot_gnt} << base;
    gnt_o   = dbl_gnt[2*NUM_PORTS-1:NUM_PORTS];
  end

  always_comb begin
    ptr_next = ptr_reg;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_o[i]) ptr_next = PTR_W'((i + 1) % NUM_PORTS);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_reg <= '0;
    end else if (|gnt_o) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/hpu_darb_mp.sv
// Debug-memory arbiter: merges debug-controller responses and NUM_PORTS requesters onto
// the DM port and routes read responses back. HPU_DARB_RR_EN selects round-robin arbitration.
module hpu_darb_mp
  import hpu_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ctrl_darb__rspd_en_i,
  input  rspd_e                       ctrl_darb__rspd_data_i,
  input  logic [NUM_PORTS-1:0]        req_darb__req_i,
  input  logic [NUM_PORTS-1:0]        req_darb__we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_darb__addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] req_darb__wdata_i,
  input  logic [NUM_PORTS*DATA_W/8-1:0] req_darb__wstrb_i,
  output logic [NUM_PORTS-1:0]        darb_req__gnt_o,
  output logic [NUM_PORTS-1:0]        darb_req__rvalid_o,
  output logic [DATA_W-1:0]           darb_req__rdata_o,
  output logic                        darb_dm__req_o,
  output logic                        darb_dm__we_o,
  output logic [ADDR_W-1:0]           darb_dm__addr_o,
  output logic [DATA_W-1:0]           darb_dm__wdata_o,
  output logic [DATA_W/8-1:0]         darb_dm__wstrb_o,
  input  logic [DATA_W-1:0]           dm_darb__rdata_i
);

  localparam int STRB_W = DATA_W / 8;

`ifdef HPU_DARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] addr_a  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_a [NUM_PORTS];
  logic [STRB_W-1:0] wstrb_a [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_a[gi]  = req_darb__addr_i[gi*ADDR_W +: ADDR_W];
      assign wdata_a[gi] = req_darb__wdata_i[gi*DATA_W +: DATA_W];
      assign wstrb_a[gi] = req_darb__wstrb_i[gi*STRB_W +: STRB_W];
    end
  endgenerate

  // Requesters only compete when neither reset nor a debug response owns the cycle.
  logic [NUM_PORTS-1:0] arb_req, gnt;
  assign arb_req = req_darb__req_i & {NUM_PORTS{~(rst_i | ctrl_darb__rspd_en_i)}};

  hpu_darb_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rr_en_i (RR_EN),
    .req_i   (arb_req),
    .gnt_o   (gnt)
  );

  assign darb_req__gnt_o = gnt;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        sel_we    = req_darb__we_i[i];
        sel_addr  = addr_a[i];
        sel_wdata = wdata_a[i];
        sel_wstrb = wstrb_a[i];
      end
    end
  end

  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [STRB_W-1:0] wstrb_reg, wstrb_next;
  darb_port_id_t     id_reg, id_next;

  always_comb begin
    req_next   = 1'b0;
    we_next    = 1'b0;
    addr_next  = '0;
    wdata_next = '0;
    wstrb_next = '0;
    id_next    = '0;
    if (ctrl_darb__rspd_en_i) begin
      req_next   = 1'b1;
      we_next    = 1'b1;
      addr_next  = ADDR_W'(darb_rspd_addr(ctrl_darb__rspd_data_i));
      wstrb_next = '1;
    end else if (|gnt) begin
      req_next   = 1'b1;
      we_next    = sel_we;
      addr_next  = sel_addr;
      wdata_next = sel_wdata;
      wstrb_next = sel_wstrb;
      if (!sel_we) id_next[NUM_PORTS-1:0] = gnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      id_reg    <= '0;
    end else begin
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wstrb_reg <= wstrb_next;
      id_reg    <= id_next;
    end
  end

  assign darb_dm__req_o   = req_reg;
  assign darb_dm__we_o    = we_reg;
  assign darb_dm__addr_o  = addr_reg;
  assign darb_dm__wdata_o = wdata_reg;
  assign darb_dm__wstrb_o = wstrb_reg;

  // The id travels alongside the DM request, so stage RD_LAT-1 lines up with rdata.
  darb_port_id_t pipe_reg [RD_LAT];

  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          pipe_reg[gi] <= '0;
        end else begin
          pipe_reg[gi] <= (gi == 0) ? id_reg : pipe_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
    if (NUM_PORTS < DARB_MAX_PORTS) begin : g_pad
      logic unused_pad;
      assign unused_pad = |pipe_reg[RD_LAT-1][DARB_MAX_PORTS-1:NUM_PORTS];
    end
  endgenerate

  assign darb_req__rvalid_o = pipe_reg[RD_LAT-1][NUM_PORTS-1:0] & {NUM_PORTS{~rst_i}};
  assign darb_req__rdata_o  = dm_darb__rdata_i;

endmodule

// File: tb/tb_hpu_darb_mp.sv
// Scoreboard bench for hpu_darb_mp: a cycle model predicts grants, DM transactions and
// routed read responses; expectations are queued when driven and popped when due.
module tb_hpu_darb_mp;
  import hpu_pkg::*;

  localparam int NP  = 3;
  localparam int RDL = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic                 rspd_en;
  rspd_e                rspd_data;
  logic [NP-1:0]        pend, p_we;
  logic [AW-1:0]        p_addr  [NP];
  logic [DW-1:0]        p_wdata [NP];
  logic [SW-1:0]        p_wstrb [NP];
  logic [NP*AW-1:0]     addr_bus;
  logic [NP*DW-1:0]     wdata_bus;
  logic [NP*SW-1:0]     wstrb_bus;

  logic [NP-1:0] gnt, rvalid;
  logic [DW-1:0] rdata, dm_rdata, dm_wdata;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [SW-1:0] dm_wstrb;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      addr_bus[i*AW +: AW]  = p_addr[i];
      wdata_bus[i*DW +: DW] = p_wdata[i];
      wstrb_bus[i*SW +: SW] = p_wstrb[i];
    end
  end

  assign dm_rdata = 32'h1234 + 32'(cyc);

  hpu_darb_mp #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .ctrl_darb__rspd_en_i   (rspd_en),
    .ctrl_darb__rspd_data_i (rspd_data),
    .req_darb__req_i        (pend),
    .req_darb__we_i         (p_we),
    .req_darb__addr_i       (addr_bus),
    .req_darb__wdata_i      (wdata_bus),
    .req_darb__wstrb_i      (wstrb_bus),
    .darb_req__gnt_o        (gnt),
    .darb_req__rvalid_o     (rvalid),
    .darb_req__rdata_o      (rdata),
    .darb_dm__req_o         (dm_req),
    .darb_dm__we_o          (dm_we),
    .darb_dm__addr_o        (dm_addr),
    .darb_dm__wdata_o       (dm_wdata),
    .darb_dm__wstrb_o       (dm_wstrb),
    .dm_darb__rdata_i       (dm_rdata)
  );

  typedef struct {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } dm_txn_t;

  typedef struct {
    int            due;
    logic [NP-1:0] id;
  } rd_txn_t;

  dm_txn_t dm_q[$];
  rd_txn_t rd_q[$];
  int      mptr = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [NP-1:0] model_gnt(input logic [NP-1:0] r, input int ptr);
    logic [NP-1:0] g;
    int p;
    g = '0;
`ifdef HPU_DARB_RR_EN
    p = ptr;
`else
    p = 0;
`endif
    for (int k = 0; k < NP; k++) begin
      if (r[p]) begin
        g[p] = 1'b1;
        return g;
      end
      p = (p + 1) % NP;
    end
    return g;
  endfunction

  function automatic logic [AW-1:0] rspd_addr(input rspd_e c);
    if (c == RSPD_HALT)   return 32'h100;
    if (c == RSPD_CMD)    return 32'h104;
    if (c == RSPD_RESUME) return 32'h108;
    return 32'h10C;
  endfunction

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    pend[p]    = 1'b1;
    p_we[p]    = we;
    p_addr[p]  = a;
    p_wdata[p] = d;
    p_wstrb[p] = s;
  endtask

  // One clock: check everything due now, queue what the model expects next.
  task automatic step();
    logic [NP-1:0] exp_g, exp_rv;
    dm_txn_t       e, n;
    rd_txn_t       r;
    int            gp;
    @(negedge clk_i);
    exp_g = (rst_i || rspd_en) ? '0 : model_gnt(pend, mptr);
    chk("gnt", 64'(gnt), 64'(exp_g));

    exp_rv = '0;
    if (!rst_i && rd_q.size() > 0 && rd_q[0].due == cyc) begin
      r = rd_q.pop_front();
      exp_rv = r.id;
    end
    chk("rvalid", 64'(rvalid), 64'(exp_rv));
    if (exp_rv != '0) begin
      chk("rdata", 64'(rdata), 64'(32'h1234 + 32'(cyc)));
      $display("rd  cyc=%0d port_oh=%b rdata=%h", cyc, rvalid, rdata);
    end

    if (dm_q.size() > 0) begin
      e = dm_q.pop_front();
      chk("dm_req", 64'(dm_req), 64'(e.req));
      chk("dm_we", 64'(dm_we), 64'(e.we));
      chk("dm_addr", 64'(dm_addr), 64'(e.addr));
      chk("dm_wdata", 64'(dm_wdata), 64'(e.wdata));
      chk("dm_wstrb", 64'(dm_wstrb), 64'(e.wstrb));
      if (e.req)
        $display("dm  cyc=%0d we=%0b addr=%h wdata=%h wstrb=%h", cyc, dm_we, dm_addr, dm_wdata, dm_wstrb);
    end

    n = '{req: 1'b0, we: 1'b0, addr: '0, wdata: '0, wstrb: '0};
    gp = -1;
    for (int i = 0; i < NP; i++) if (exp_g[i]) gp = i;
    if (rst_i) begin
      rd_q.delete();
      mptr = 0;
    end else if (rspd_en) begin
      n = '{req: 1'b1, we: 1'b1, addr: rspd_addr(rspd_data), wdata: '0, wstrb: '1};
    end else if (gp >= 0) begin
      n = '{req: 1'b1, we: p_we[gp], addr: p_addr[gp], wdata: p_wdata[gp], wstrb: p_wstrb[gp]};
      if (!p_we[gp]) rd_q.push_back('{due: cyc + 1 + RDL, id: exp_g});
      mptr = (gp + 1) % NP;
    end
    dm_q.push_back(n);

    @(posedge clk_i);
    #1;
    cyc++;
    pend = pend & ~exp_g;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (pend != '0 && n < limit) begin
      step();
      n++;
    end
    chk("idle", 64'(pend), 64'(0));
  endtask

  initial begin
    rst_i     = 1'b1;
    rspd_en   = 1'b0;
    rspd_data = RSPD_HALT;
    pend      = '0;
    p_we      = '0;
    for (int i = 0; i < NP; i++) begin
      p_addr[i]  = '0;
      p_wdata[i] = '0;
      p_wstrb[i] = '0;
    end
    @(posedge clk_i);
    #1;
    run(2);
    rst_i = 1'b0;
    run(2);

    // Two simultaneous reads: arbitration order and per-port routing
    issue(0, 1'b0, 32'h200, '0, '0);
    issue(1, 1'b0, 32'h300, '0, '0);
    wait_idle(10);
    run(RDL + 2);

    // All ports requesting continuously for six cycles
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < NP; p++)
        if (!pend[p]) issue(p, 1'b0, 32'h400 + 32'(c * 16 + p * 4), '0, '0);
      step();
    end
    wait_idle(10);
    run(RDL + 2);

    // Debug response beats a pending requester
    issue(0, 1'b0, 32'h500, '0, '0);
    rspd_en   = 1'b1;
    rspd_data = RSPD_RESUME;
    step();
    rspd_en = 1'b0;
    wait_idle(5);
    for (int k = 0; k < 4; k++) begin
      rspd_en   = 1'b1;
      rspd_data = rspd_e'(k);
      step();
    end
    rspd_en = 1'b0;
    run(RDL + 2);

    // Strobed write: forwarded unchanged, never produces a response
    issue(1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'h3);
    wait_idle(5);
    run(RDL + 2);

    // Single read latency
    issue(0, 1'b0, 32'h600, '0, '0);
    wait_idle(5);
    run(RDL + 2);

    // Reset one cycle after a read grant drops the response
    issue(2, 1'b0, 32'h700, '0, '0);
    wait_idle(5);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    run(RDL + 3);

    // Back-to-back mixed reads and writes after reset
    issue(0, 1'b0, 32'h800, '0, '0);
    issue(1, 1'b1, 32'h804, 32'h5555_AAAA, 4'hC);
    issue(2, 1'b0, 32'h808, '0, '0);
    wait_idle(10);
    run(RDL + 3);

    chk("rd_drained", 64'(rd_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
